sterownik_obrotow: RTL and testbench

//  Sequencer feeding the odliczanie countdown datapath: drives rozruch, taktowanie_na_stopien and

---
 rtl/sterownik_obrotow_if.sv | 25 ++
 rtl/sterownik_obrotow.sv | 205 ++++++++++++++++++++
 tb/tb_sterownik_obrotow.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sterownik_obrotow_if.sv
// Bundle of the sequencer's command/status signals towards the countdown datapath.
// slave  : the sequencer side (consumes commands and the revolution count).
// master : the commanding side (drives start/stop/target and the revolution count).
interface sterownik_obrotow_if;
    logic       start;
    logic       stop;
    logic [8:0] zadane_taktowanie;
    logic [3:0] zliczanie_obrotow;
    logic       rozruch;
    logic [8:0] taktowanie_na_stopien;
    logic       sygnal_zmiany_rpm;
    logic [2:0] stan;
    logic       gotowe;
    logic       blad;

    modport slave (
        input  start, stop, zadane_taktowanie, zliczanie_obrotow,
        output rozruch, taktowanie_na_stopien, sygnal_zmiany_rpm, stan, gotowe, blad
    );

    modport master (
        output start, stop, zadane_taktowanie, zliczanie_obrotow,
        input  rozruch, taktowanie_na_stopien, sygnal_zmiany_rpm, stan, gotowe, blad
    );
endinterface

// File: rtl/sterownik_obrotow.sv
// Engine speed sequencer: cranking, per-revolution ramp to a commanded ticks/degree,
// steady run, ramp-down and stall detection. All outputs are registered.
module sterownik_obrotow #(
    parameter int unsigned TAKT_ROZRUCHU   = 400,
    parameter int unsigned TAKT_MIN        = 4,
    parameter int unsigned KROK            = 8,
    parameter int unsigned OBROTY_ROZRUCHU = 2,
    parameter int unsigned TIMEOUT         = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sterownik_obrotow_if.slave   bus
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [8:0]    L_MAX      = 9'(TAKT_ROZRUCHU);
    localparam logic [8:0]    L_MIN      = 9'(TAKT_MIN);
    localparam logic [9:0]    L_KROK     = 10'(KROK);
    localparam logic [3:0]    L_OBROTY   = 4'(OBROTY_ROZRUCHU);
    localparam logic [TW-1:0] L_TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        BEZCZYNNY = 3'd0,
        ROZRUCH   = 3'd1,
        RAMPA     = 3'd2,
        PRACA     = 3'd3,
        HAMOWANIE = 3'd4,
        BLAD      = 3'd5
    } stan_t;

    stan_t         r_stan;
    stan_t         w_stan_n;
    logic [8:0]    r_takt;
    logic [8:0]    w_takt_n;
    logic [3:0]    r_zl_s;
    logic [3:0]    r_zl_p;
    logic [3:0]    r_obr_cnt;
    logic [3:0]    w_obr_cnt_n;
    logic [TW-1:0] r_tmo;
    logic          r_rozruch;
    logic          r_zmiana;
    logic          r_gotowe;
    logic          r_blad;
    logic          w_obr;
    logic          w_timeout;
    logic          w_aktywny_n;
    logic [8:0]    w_cel;

    // One ramp step from t toward c; computed 10 bits wide and lands exactly on c.
    function automatic logic [8:0] krok_ku(input logic [8:0] t, input logic [8:0] c);
        logic [9:0] t10;
        logic [9:0] c10;
        t10 = {1'b0, t};
        c10 = {1'b0, c};
        if (t10 > c10 + L_KROK) begin
            krok_ku = 9'(t10 - L_KROK);
        end else if (t10 + L_KROK < c10) begin
            krok_ku = 9'(t10 + L_KROK);
        end else begin
            krok_ku = c;
        end
    endfunction

    assign w_obr       = (r_zl_s != r_zl_p);
    assign w_aktywny_n = (w_stan_n != BEZCZYNNY) && (w_stan_n != BLAD);
    assign w_timeout   = (r_stan != BEZCZYNNY) && (r_stan != BLAD) && (r_tmo == L_TMO_LAST);

    // Clamp the commanded speed into the legal ticks/degree window.
    always_comb begin
        if (bus.zadane_taktowanie < L_MIN) begin
            w_cel = L_MIN;
        end else if (bus.zadane_taktowanie > L_MAX) begin
            w_cel = L_MAX;
        end else begin
            w_cel = bus.zadane_taktowanie;
        end
    end

    // Next-state and next speed; timeout beats stop beats start beats a revolution step.
    always_comb begin
        w_stan_n    = r_stan;
        w_takt_n    = r_takt;
        w_obr_cnt_n = r_obr_cnt;
        if (w_timeout) begin
            w_stan_n = BLAD;
            w_takt_n = L_MAX;
        end else begin
            case (r_stan)
                BEZCZYNNY: begin
                    w_obr_cnt_n = 4'd0;
                    if (bus.start && !bus.stop) begin
                        w_stan_n = ROZRUCH;
                    end else begin
                        w_stan_n = BEZCZYNNY;
                    end
                end
                ROZRUCH: begin
                    if (bus.stop) begin
                        w_stan_n = BEZCZYNNY;
                    end else if (w_obr) begin
                        w_obr_cnt_n = r_obr_cnt + 4'd1;
                        if (r_obr_cnt + 4'd1 == L_OBROTY) begin
                            w_stan_n = RAMPA;
                        end else begin
                            w_stan_n = ROZRUCH;
                        end
                    end else begin
                        w_stan_n = ROZRUCH;
                    end
                end
                RAMPA: begin
                    if (bus.stop) begin
                        w_stan_n = HAMOWANIE;
                    end else if (r_takt == w_cel) begin
                        w_stan_n = PRACA;
                    end else if (w_obr) begin
                        w_takt_n = krok_ku(r_takt, w_cel);
                    end else begin
                        w_stan_n = RAMPA;
                    end
                end
                PRACA: begin
                    if (bus.stop) begin
                        w_stan_n = HAMOWANIE;
                    end else if (r_takt != w_cel) begin
                        w_stan_n = RAMPA;
                    end else begin
                        w_stan_n = PRACA;
                    end
                end
                HAMOWANIE: begin
                    if (r_takt == L_MAX) begin
                        w_stan_n = BEZCZYNNY;
                    end else if (w_obr) begin
                        w_takt_n = krok_ku(r_takt, L_MAX);
                    end else begin
                        w_stan_n = HAMOWANIE;
                    end
                end
                BLAD: begin
                    w_takt_n = L_MAX;
                    if (bus.stop) begin
                        w_stan_n = BEZCZYNNY;
                    end else begin
                        w_stan_n = BLAD;
                    end
                end
                default: begin
                    w_stan_n = BEZCZYNNY;
                    w_takt_n = L_MAX;
                end
            endcase
        end
    end

    // State, speed and status registers; strobe marks the cycle a new speed first appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stan    <= BEZCZYNNY;
            r_takt    <= L_MAX;
            r_obr_cnt <= 4'd0;
            r_rozruch <= 1'b0;
            r_zmiana  <= 1'b0;
            r_gotowe  <= 1'b0;
            r_blad    <= 1'b0;
        end else begin
            r_stan    <= w_stan_n;
            r_takt    <= w_takt_n;
            r_obr_cnt <= w_obr_cnt_n;
            r_rozruch <= w_aktywny_n;
            r_zmiana  <= (w_takt_n != r_takt);
            r_gotowe  <= (w_stan_n == PRACA);
            r_blad    <= (w_stan_n == BLAD);
        end
    end

    // Revolution count sample and its previous value; any difference is one revolution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zl_s <= 4'd0;
            r_zl_p <= 4'd0;
        end else begin
            r_zl_s <= bus.zliczanie_obrotow;
            r_zl_p <= r_zl_s;
        end
    end

    // Stall watchdog: counts cycles without a revolution while the engine is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if ((w_stan_n != r_stan) || w_obr || !w_aktywny_n) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    assign bus.rozruch               = r_rozruch;
    assign bus.taktowanie_na_stopien = r_takt;
    assign bus.sygnal_zmiany_rpm     = r_zmiana;
    assign bus.stan                  = r_stan;
    assign bus.gotowe                = r_gotowe;
    assign bus.blad                  = r_blad;
endmodule

// File: tb/tb_sterownik_obrotow.sv
// Bench for sterownik_obrotow: speed values expected on each change strobe are queued
// when a revolution is driven and compared when the strobe appears.
module tb_sterownik_obrotow;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   oczekiwane[$];

    always #5 clk = ~clk;

    sterownik_obrotow_if bus();

    sterownik_obrotow #(
        .TAKT_ROZRUCHU(40), .TAKT_MIN(4), .KROK(8), .OBROTY_ROZRUCHU(2), .TIMEOUT(1000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic sprawdz(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every change strobe must match the oldest queued speed.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.sygnal_zmiany_rpm === 1'b1) begin
            if (oczekiwane.size() == 0) begin
                sprawdz("strobe_unexpected", int'(bus.taktowanie_na_stopien), -1);
            end else begin
                sprawdz("takt_at_strobe", int'(bus.taktowanie_na_stopien), oczekiwane.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic obrot();
        bus.zliczanie_obrotow = bus.zliczanie_obrotow + 4'd1;
        tick(4);
    endtask

    task automatic czekaj_stan(input int v, input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            if (int'(bus.stan) == v) break;
            tick(1);
        end
        sprawdz(tag, int'(bus.stan), v);
    endtask

    task automatic sprawdz_reset(input string tag);
        sprawdz({tag, "_stan"}, int'(bus.stan), 0);
        sprawdz({tag, "_takt"}, int'(bus.taktowanie_na_stopien), 40);
        sprawdz({tag, "_rozruch"}, int'(bus.rozruch), 0);
        sprawdz({tag, "_strobe"}, int'(bus.sygnal_zmiany_rpm), 0);
        sprawdz({tag, "_gotowe"}, int'(bus.gotowe), 0);
        sprawdz({tag, "_blad"}, int'(bus.blad), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.zadane_taktowanie = 9'd0;
        bus.zliczanie_obrotow = 4'd0;
        tick(3);
        sprawdz_reset("reset");
        rst_n = 1'b1;
        tick(2);

        // start -> cranking, slow speed, no strobe
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        sprawdz("start_stan", int'(bus.stan), 1);
        sprawdz("start_rozruch", int'(bus.rozruch), 1);
        sprawdz("start_takt", int'(bus.taktowanie_na_stopien), 40);
        sprawdz("start_strobe", int'(bus.sygnal_zmiany_rpm), 0);

        // two cranking revolutions, then ramp 40 -> 4 (target 0 clamps to 4)
        obrot();
        sprawdz("crank_still", int'(bus.stan), 1);
        obrot();
        sprawdz("ramp_entry", int'(bus.stan), 2);
        oczekiwane.push_back(32); oczekiwane.push_back(24); oczekiwane.push_back(16);
        oczekiwane.push_back(8);  oczekiwane.push_back(4);
        repeat (5) obrot();
        sprawdz("run_stan", int'(bus.stan), 3);
        sprawdz("run_gotowe", int'(bus.gotowe), 1);
        sprawdz("run_takt", int'(bus.taktowanie_na_stopien), 4);
        sprawdz("queue_after_ramp", oczekiwane.size(), 0);

        // new target 20 from run
        bus.zadane_taktowanie = 9'd20;
        tick(1);
        sprawdz("retarget_stan", int'(bus.stan), 2);
        sprawdz("retarget_gotowe", int'(bus.gotowe), 0);
        oczekiwane.push_back(12); oczekiwane.push_back(20);
        repeat (2) obrot();
        sprawdz("run20_stan", int'(bus.stan), 3);

        // direction reversal mid-ramp, then oversized target clamps to 40
        bus.zadane_taktowanie = 9'd4;
        oczekiwane.push_back(12);
        tick(1);
        obrot();
        bus.zadane_taktowanie = 9'd500;
        oczekiwane.push_back(20); oczekiwane.push_back(28);
        oczekiwane.push_back(36); oczekiwane.push_back(40);
        repeat (4) obrot();
        sprawdz("clamp_stan", int'(bus.stan), 3);
        sprawdz("clamp_takt", int'(bus.taktowanie_na_stopien), 40);
        bus.zadane_taktowanie = 9'd20;
        oczekiwane.push_back(32); oczekiwane.push_back(24); oczekiwane.push_back(20);
        repeat (3) obrot();
        sprawdz("back20_takt", int'(bus.taktowanie_na_stopien), 20);
        sprawdz("back20_stan", int'(bus.stan), 3);

        // stop in run -> ramp-down to 40, then idle
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        sprawdz("brake_stan", int'(bus.stan), 4);
        sprawdz("brake_rozruch", int'(bus.rozruch), 1);
        oczekiwane.push_back(28); oczekiwane.push_back(36); oczekiwane.push_back(40);
        repeat (3) obrot();
        czekaj_stan(0, 10, "brake_done_stan");
        sprawdz("brake_done_rozruch", int'(bus.rozruch), 0);
        sprawdz("queue_after_brake", oczekiwane.size(), 0);

        // start and stop together in idle: stop wins
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick(3);
        sprawdz("start_stop_stan", int'(bus.stan), 0);
        bus.start = 1'b0;
        bus.stop = 1'b0;

        // stall during ramp -> fault
        bus.zadane_taktowanie = 9'd4;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        repeat (2) obrot();
        sprawdz("stall_ramp", int'(bus.stan), 2);
        tick(900);
        sprawdz("stall_not_yet", int'(bus.stan), 2);
        czekaj_stan(5, 300, "stall_stan");
        sprawdz("stall_blad", int'(bus.blad), 1);
        sprawdz("stall_rozruch", int'(bus.rozruch), 0);
        sprawdz("stall_takt", int'(bus.taktowanie_na_stopien), 40);
        bus.start = 1'b1;
        tick(3);
        sprawdz("fault_start_ignored", int'(bus.stan), 5);
        bus.start = 1'b0;
        bus.stop = 1'b1;
        czekaj_stan(0, 5, "fault_ack_stan");
        bus.stop = 1'b0;
        tick(1);
        sprawdz("fault_ack_blad", int'(bus.blad), 0);

        // 15 -> 0 wrap counts as a revolution
        bus.zliczanie_obrotow = 4'd14;
        tick(3);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        obrot();
        obrot();
        sprawdz("wrap_ramp_entry", int'(bus.stan), 2);
        oczekiwane.push_back(32);
        obrot();
        sprawdz("wrap_step_takt", int'(bus.taktowanie_na_stopien), 32);

        // asynchronous reset mid-ramp, checked before the next clock edge
        #2 rst_n = 1'b0;
        #1;
        sprawdz_reset("async_reset");
        oczekiwane.delete();
        #10 rst_n = 1'b1;
        tick(3);
        sprawdz("post_reset_stan", int'(bus.stan), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
